float_multiplier_param: RTL and testbench
=========================================

FLOAT_MULTIPLIER_PARAM -- requirements
Module: float_multiplier_param

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (2..10).
REQ-002 SHALL have parameter MAN_W, default 7, stored mantissa width (1..23).
REQ-003 SHALL have parameter BIAS, default 2**(EXP_W-1)-1, exponent bias.
REQ-004 SHALL have port clock  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  operands a/b present.
REQ-007 SHALL have port in_ready  output  1  block can accept operands.
REQ-008 SHALL have ports a, b  input  1+EXP_W+MAN_W  operands {sign, exponent, mantissa}.
REQ-009 SHALL have port out_valid  output  1  y and flags hold a result.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port y  output  1+EXP_W+MAN_W  product, same format as a/b.
REQ-012 SHALL have port overflow  output  1  result saturated.
REQ-013 SHALL have port underflow  output  1  result flushed to zero.

Function
REQ-014 SHALL implement FSM IDLE -> MUL -> NORM -> ROUND -> DONE -> IDLE, one state per cycle except DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE; a, b captured into internal registers on in_valid&&in_ready.
REQ-016 MUL: SHALL register 2*(MAN_W+1)-bit product of {1,man_a}*{1,man_b}, and signed (EXP_W+2)-bit sum exp_a+exp_b-BIAS.
REQ-017 NORM: if product MSB=1, SHALL shift product right one bit (LSB into sticky) and increment exponent.
REQ-018 ROUND: SHALL take MAN_W bits below the leading one, guard = next bit, sticky = OR of all remaining bits.
REQ-019 ROUND: if rounding carries out of mantissa, SHALL reset mantissa to zero and increment exponent.
REQ-020 Sign SHALL be sign_a XOR sign_b in all cases, including zero and saturated results.
REQ-021 Operand with exponent field 0 SHALL be treated as zero (subnormals flushed); result = signed zero, no flags.
REQ-022 Exponent field all-ones SHALL be an ordinary normal exponent; no Inf/NaN encodings exist.
REQ-023 Final biased exponent > 2**EXP_W-1 SHALL yield exponent and mantissa all ones, overflow=1.
REQ-024 Final biased exponent <= 0 SHALL yield signed zero, underflow=1.
REQ-025 DONE: out_valid=1; y, overflow, underflow SHALL stay stable until out_valid&&out_ready, then return to IDLE.
REQ-026 Latency: out_valid SHALL rise on the 4th rising edge after the accepting edge, independent of operand values.
REQ-027 in_valid arriving outside IDLE SHALL be ignored (not queued); one operation in flight at most.

Reset
REQ-028 reset_n=0 SHALL asynchronously force IDLE, in_ready=1, out_valid=0, y=0, overflow=0, underflow=0, all datapath registers 0.
REQ-029 Reset during any state SHALL abort the operation; no result is produced after release.
REQ-030 After reset_n rises, first acceptance SHALL occur on the first edge with in_valid=1.

Configuration
REQ-031 Macro FLOAT_MUL_ROUND_NEAREST_EN defined: ROUND SHALL round to nearest even (increment if guard && (sticky || mantissa LSB)).
REQ-032 Macro FLOAT_MUL_ROUND_NEAREST_EN undefined: ROUND SHALL truncate (no increment); state sequence and latency unchanged.

Verification (defaults EXP_W=8, MAN_W=7)
REQ-033 0x3FC0*0x3FC0 (1.5*1.5) -> y=0x4010, flags 0, out_valid exactly 4 edges after accept.
REQ-034 0x3F81*0x3FC0 (tie case) -> y=0x3FC2 with FLOAT_MUL_ROUND_NEAREST_EN, 0x3FC1 without.
REQ-035 0xFF80*0x7F80 -> y=0xFFFF, overflow=1; 0x0080*0x0080 -> y=0x0000, underflow=1.
REQ-036 0x8000*0x3F80 -> y=0x8000, flags 0; 0x0001*0x3F80 (subnormal) -> y=0x0000, flags 0.
REQ-037 Hold out_ready=0 for 3 cycles in DONE -> y/out_valid stable, in_ready=0, new in_valid ignored; result consumed on out_ready=1.
REQ-038 Assert reset_n=0 in NORM -> outputs at reset values immediately, no out_valid after release, next operation correct.

Source files
------------

// File: rtl/float_multiplier_param.sv
// float_multiplier_param: multi-cycle {sign, exponent, mantissa} multiplier with saturation and flush-to-zero.
// Macro FLOAT_MUL_ROUND_NEAREST_EN selects round-to-nearest-even; without it the mantissa is truncated.
// state | meaning
// IDLE  | waiting for operands, in_ready high
// MUL   | significand product and biased exponent sum
// NORM  | single-bit normalisation into sticky
// ROUND | mantissa selection and rounding
// DONE  | pack result on first cycle, then hold until consumed
module float_multiplier_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7,
  parameter int BIAS  = 2**(EXP_W-1)-1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] y,
  output logic                 overflow,
  output logic                 underflow
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * (MAN_W + 1);
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] BIAS_S   = XW'(BIAS);
  localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
  localparam logic signed [XW-1:0] EXP_ZERO = XW'(0);
  localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);
  localparam logic [PW-1:0] REST_MASK = (PW'(1) << (MAN_W - 1)) - PW'(1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_NORM, S_ROUND, S_DONE} state_t;

  state_t               r_state;
  logic [W-1:0]         r_a;
  logic [W-1:0]         r_b;
  logic [PW-1:0]        r_prod;
  logic signed [XW-1:0] r_exp;
  logic                 r_sticky;
  logic                 r_sign;
  logic                 r_zero;
  logic [MAN_W-1:0]     r_man;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [W-1:0]         r_y;
  logic                 r_ovf;
  logic                 r_unf;

  logic [EXP_W-1:0]     w_exp_a;
  logic [EXP_W-1:0]     w_exp_b;
  logic [MAN_W-1:0]     w_man_a;
  logic [MAN_W-1:0]     w_man_b;
  logic [PW-1:0]        w_prod;
  logic signed [XW-1:0] w_exp_sum;
  logic [MAN_W-1:0]     w_man_trunc;
  logic                 w_guard;
  logic                 w_sticky;
  logic                 w_inc;
  logic [MAN_W:0]       w_man_sum;

  assign w_exp_a   = r_a[W-2 -: EXP_W];
  assign w_exp_b   = r_b[W-2 -: EXP_W];
  assign w_man_a   = r_a[MAN_W-1:0];
  assign w_man_b   = r_b[MAN_W-1:0];
  assign w_prod    = PW'({1'b1, w_man_a}) * PW'({1'b1, w_man_b});
  assign w_exp_sum = $signed({2'b00, w_exp_a}) + $signed({2'b00, w_exp_b}) - BIAS_S;

  // after NORM the leading one sits at bit PW-2
  assign w_man_trunc = r_prod[2*MAN_W-1 -: MAN_W];
  assign w_guard     = r_prod[MAN_W-1];
  assign w_sticky    = r_sticky | (|(r_prod & REST_MASK));

`ifdef FLOAT_MUL_ROUND_NEAREST_EN
  assign w_inc = w_guard & (w_sticky | w_man_trunc[0]);
`else
  logic w_unused_round;
  assign w_unused_round = w_guard | w_sticky;
  assign w_inc          = 1'b0;
`endif

  assign w_man_sum = {1'b0, w_man_trunc} + (MAN_W+1)'(w_inc);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_prod      <= '0;
      r_exp       <= '0;
      r_sticky    <= 1'b0;
      r_sign      <= 1'b0;
      r_zero      <= 1'b0;
      r_man       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_in_ready <= 1'b0;
            r_state    <= S_MUL;
          end
        end
        S_MUL: begin
          r_prod   <= w_prod;
          r_exp    <= w_exp_sum;
          r_sticky <= 1'b0;
          r_sign   <= r_a[W-1] ^ r_b[W-1];
          r_zero   <= (w_exp_a == '0) || (w_exp_b == '0);
          r_state  <= S_NORM;
        end
        S_NORM: begin
          if (r_prod[PW-1]) begin
            r_prod   <= r_prod >> 1;
            r_sticky <= r_prod[0];
            r_exp    <= r_exp + EXP_ONE;
          end
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          if (w_man_sum[MAN_W]) begin
            r_man <= '0;
            r_exp <= r_exp + EXP_ONE;
          end else begin
            r_man <= w_man_sum[MAN_W-1:0];
          end
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            if (r_zero) begin
              r_y   <= {r_sign, {(W-1){1'b0}}};
              r_ovf <= 1'b0;
              r_unf <= 1'b0;
            end else if (r_exp > EXP_MAX) begin
              r_y   <= {r_sign, {(W-1){1'b1}}};
              r_ovf <= 1'b1;
              r_unf <= 1'b0;
            end else if (r_exp <= EXP_ZERO) begin
              r_y   <= {r_sign, {(W-1){1'b0}}};
              r_ovf <= 1'b0;
              r_unf <= 1'b1;
            end else begin
              r_y   <= {r_sign, r_exp[EXP_W-1:0], r_man};
              r_ovf <= 1'b0;
              r_unf <= 1'b0;
            end
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: tb/tb_float_multiplier_param.sv
// Self-checking bench for float_multiplier_param at default widths (EXP_W=8, MAN_W=7).
// Expected results come from an integer-arithmetic model of the number format.
module tb_float_multiplier_param;
  logic        clock     = 1'b0;
  logic        reset_n   = 1'b1;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a         = '0;
  logic [15:0] b         = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] y;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  float_multiplier_param dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .overflow (overflow),
    .underflow(underflow)
  );

  // Exact significand product, one-bit normalisation, then rounding decided on the discarded remainder.
  task automatic model(input logic [15:0] x, input logic [15:0] z,
                       output logic [15:0] ey, output logic eov, output logic eun);
    int ex, ez, p, e, man, rem, lost, inc;
    logic s;
    s   = x[15] ^ z[15];
    ex  = int'(x[14:7]);
    ez  = int'(z[14:7]);
    eov = 1'b0;
    eun = 1'b0;
    if (ex == 0 || ez == 0) begin
      ey = {s, 15'h0000};
      return;
    end
    p    = (128 + int'(x[6:0])) * (128 + int'(z[6:0]));
    e    = ex + ez - 127;
    lost = 0;
    if (p >= 32768) begin
      lost = p % 2;
      p    = p / 2;
      e    = e + 1;
    end
    man = (p / 128) % 128;
    rem = p % 128;
    inc = 0;
`ifdef FLOAT_MUL_ROUND_NEAREST_EN
    if (rem > 64 || (rem == 64 && (lost != 0 || man % 2 == 1))) inc = 1;
`endif
    man = man + inc;
    if (man == 128) begin
      man = 0;
      e   = e + 1;
    end
    if (e > 255) begin
      ey  = {s, 15'h7FFF};
      eov = 1'b1;
    end else if (e <= 0) begin
      ey  = {s, 15'h0000};
      eun = 1'b1;
    end else begin
      ey = {s, 8'(e), 7'(man)};
    end
  endtask

  // Drives one operation from IDLE; lat is edges from accept to out_valid, -1 on timeout.
  task automatic run_op(input logic [15:0] xa, input logic [15:0] xb, input int hold,
                        output logic [15:0] ry, output logic rov, output logic run, output int lat);
    lat = -1;
    @(negedge clock);
    a         = xa;
    b         = xb;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    ry  = y;
    rov = overflow;
    run = underflow;
    if (lat > 0) begin
      repeat (hold) @(posedge clock);
      @(negedge clock);
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #2;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (y !== 16'h0000) begin errors++; $display("FAIL reset_y: got %h expected 0000", y); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b expected 0", underflow); end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] va [6];
    logic [15:0] vb [6];
    logic [15:0] vy [6];
    logic        vo [6];
    logic        vu [6];
    logic [15:0] ry;
    logic        rov, run;
    int          lat;
    va = '{16'h3FC0, 16'h3F81, 16'hFF80, 16'h0080, 16'h8000, 16'h0001};
    vb = '{16'h3FC0, 16'h3FC0, 16'h7F80, 16'h0080, 16'h3F80, 16'h3F80};
`ifdef FLOAT_MUL_ROUND_NEAREST_EN
    vy = '{16'h4010, 16'h3FC2, 16'hFFFF, 16'h0000, 16'h8000, 16'h0000};
`else
    vy = '{16'h4010, 16'h3FC1, 16'hFFFF, 16'h0000, 16'h8000, 16'h0000};
`endif
    vo = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vu = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], i % 2, ry, rov, run, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL dir_latency[%0d]: got %0d expected 4", i, lat); end
      checks++; if (ry !== vy[i]) begin errors++; $display("FAIL dir_y[%0d] %h*%h: got %h expected %h", i, va[i], vb[i], ry, vy[i]); end
      checks++; if (rov !== vo[i]) begin errors++; $display("FAIL dir_overflow[%0d]: got %b expected %b", i, rov, vo[i]); end
      checks++; if (run !== vu[i]) begin errors++; $display("FAIL dir_underflow[%0d]: got %b expected %b", i, run, vu[i]); end
    end
  endtask

  task automatic test_random();
    logic [15:0] xa, xb, ry, ey;
    logic        rov, run, eov, eun;
    int          lat;
    for (int n = 0; n < 200; n++) begin
      xa = 16'($urandom);
      xb = 16'($urandom);
      if ($urandom_range(0, 7) == 0) xa[14:7] = 8'h00;
      if ($urandom_range(0, 3) == 0) xb[14:7] = 8'(127 + $urandom_range(0, 4) - 2);
      model(xa, xb, ey, eov, eun);
      run_op(xa, xb, int'($urandom_range(0, 2)), ry, rov, run, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL rnd_latency %h*%h: got %0d expected 4", xa, xb, lat); end
      checks++; if (ry !== ey) begin errors++; $display("FAIL rnd_y %h*%h: got %h expected %h", xa, xb, ry, ey); end
      checks++; if (rov !== eov) begin errors++; $display("FAIL rnd_overflow %h*%h: got %b expected %b", xa, xb, rov, eov); end
      checks++; if (run !== eun) begin errors++; $display("FAIL rnd_underflow %h*%h: got %b expected %b", xa, xb, run, eun); end
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    bit got;
    @(negedge clock);
    a        = 16'h3FC0;
    b        = 16'h3FC0;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL bp_out_valid_timeout: got %b expected 1", got); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      in_valid  = 1'b1;
      a         = 16'h4000;
      b         = 16'h4000;
      out_ready = 1'b0;
      @(posedge clock);
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++; if (y !== 16'h4010) begin errors++; $display("FAIL bp_hold_y[%0d]: got %h expected 4010", i, y); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
    end
    @(negedge clock);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_consume_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_consume_in_ready: got %b expected 1", in_ready); end
    seen = 1'b0;
    repeat (8) begin
      @(posedge clock);
      #1;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL bp_ignored_input: got %b expected 0", seen); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] ry, ey;
    logic        rov, run, eov, eun;
    int          lat;
    bit          seen;
    @(negedge clock);
    a        = 16'hFF80;
    b        = 16'h7F80;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (y !== 16'h0000) begin errors++; $display("FAIL mid_reset_y: got %h expected 0000", y); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_reset_overflow: got %b expected 0", overflow); end
    @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clock);
      #1;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_reset_aborted: got %b expected 0", seen); end
    model(16'h3F81, 16'h3FC0, ey, eov, eun);
    run_op(16'h3F81, 16'h3FC0, 0, ry, rov, run, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL mid_next_latency: got %0d expected 4", lat); end
    checks++; if (ry !== ey) begin errors++; $display("FAIL mid_next_y: got %h expected %h", ry, ey); end
    checks++; if (rov !== eov || run !== eun) begin errors++; $display("FAIL mid_next_flags: got %b%b expected %b%b", rov, run, eov, eun); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
